online_div_sequencer: RTL and testbench
=======================================

ONLINE_DIV_SEQUENCER -- requirements
Module: online_div_sequencer

Interface
REQ-001 Parameter N, default 8, operand/quotient length in radix-2 signed digits.
REQ-002 Parameter DELTA, default 3, divider on-line delay; zero-digit pads fed after operands.
REQ-003 Parameter TIMEOUT, default 255, maximum idle cycles between transfers before abort.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req_a, req_b  in  1 each  requester A/B has a job pending.
REQ-007 x_a, d_a, x_b, d_b  in  2N each  dividend/divisor digit vectors, digit i at bits [2i+1:2i], digit N-1 most significant.
REQ-008 gnt_a, gnt_b  out  1 each  one-cycle pulse; operands of that requester are latched this cycle.
REQ-009 div_x, div_d  out  2 each  digit pair to divider.
REQ-010 div_in_vd  out  1  digit pair valid; div_in_rd  in  1  divider accepts.
REQ-011 div_q  in  2  quotient digit; div_out_vd  in  1  valid; div_out_rd  out  1  sequencer accepts.
REQ-012 res_vd  out  1; res_rd  in  1; res_q  out  2N; res_id  out  1 (0=A, 1=B); res_err  out  1 (timeout abort).
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 Digit encoding 2'b00=0, 2'b01=+1, 2'b10=-1; values pass through unmodified; pad digit is 2'b00.
REQ-015 States IDLE, FEED, DRAIN, DONE; transfer in = div_in_vd&&div_in_rd; transfer out = div_out_vd&&div_out_rd.
REQ-016 IDLE: if any req, issue one grant, latch that requester's x/d and id, go FEED next cycle.
REQ-017 Arbitration round-robin: both requests high -> grant requester not granted last; after reset A has priority.
REQ-018 FEED: div_in_vd=1; digits sent MSD first, digit N-1 down to 0, then DELTA pad pairs (00,00); total N+DELTA transfers in.
REQ-019 div_x/div_d SHALL stay stable while div_in_vd=1 and div_in_rd=0; advance only on transfer in.
REQ-020 After last transfer in, div_in_vd=0 next cycle; go DRAIN, or DONE directly if N quotient digits already captured.
REQ-021 div_out_rd=1 in FEED and DRAIN while fewer than N quotient digits captured; 0 otherwise.
REQ-022 First captured quotient digit written to res_q[2N-1:2N-2], subsequent digits to successively lower positions.
REQ-023 Transfer in and transfer out in the same cycle SHALL both be counted.
REQ-024 DRAIN -> DONE on cycle after Nth transfer out; quotient digits offered once N captured are left unaccepted.
REQ-025 DONE: res_vd=1 with res_q, res_id, res_err stable; on res_vd&&res_rd go IDLE next cycle, res_vd=0.
REQ-026 No grant issued while in FEED, DRAIN or DONE; requests held off, not dropped.
REQ-027 Watchdog: cycle counter cleared on any transfer and on FEED entry; reaching TIMEOUT in FEED/DRAIN -> DONE with res_err=1, uncaptured res_q digits 00.
REQ-028 res_err=0 for every job completing normally.
REQ-029 Digit counters sized ceil(log2(N+DELTA+1)); no wrap-around within a job.

Reset
REQ-030 rst_n=0 at a clock edge: state IDLE, all outputs 0 (gnt_*, div_*, res_*, busy), counters 0, round-robin pointer to A.
REQ-031 Reset mid-job abandons the job without a result; no grant in the first cycle after rst_n rises.

Verification
REQ-032 Single A job, divider always ready, x_a=16'h0055, d_a=16'h0001 -> gnt_a one pulse, 11 transfers in (8 operand + 3 pad), 8 transfers out, res_vd with res_id=0, res_err=0, res_q equal to returned digits MSD first.
REQ-033 req_a=req_b=1 from reset, two jobs -> order A then B, then A when both requests repeat; no overlapping grants.
REQ-034 div_in_rd toggled 1-of-3 cycles -> div_x/div_d constant across every stall, exactly 11 transfers in, no digit skipped or repeated.
REQ-035 div_out_vd held 0 after 4 quotient digits -> res_vd after TIMEOUT (255) idle cycles, res_err=1, low 4 digits of res_q = 00.
REQ-036 res_rd held 0 for 20 cycles in DONE with req_b=1 -> res_* stable, gnt_b not asserted until cycle after res_rd.
REQ-037 rst_n=0 for one cycle during FEED -> all outputs 0 next cycle, later req_a job completes normally.

Source files
------------

// File: rtl/online_div_sequencer_if.sv
// Handshake and data bundle between the on-line divider sequencer, its two
// requesters, the divider core and the result consumer.
interface online_div_sequencer_if #(
   parameter int N = 8
);
   logic           req_a;
   logic           req_b;
   logic [2*N-1:0] x_a;
   logic [2*N-1:0] d_a;
   logic [2*N-1:0] x_b;
   logic [2*N-1:0] d_b;
   logic           gnt_a;
   logic           gnt_b;
   logic [1:0]     div_x;
   logic [1:0]     div_d;
   logic           div_in_vd;
   logic           div_in_rd;
   logic [1:0]     div_q;
   logic           div_out_vd;
   logic           div_out_rd;
   logic           res_vd;
   logic           res_rd;
   logic [2*N-1:0] res_q;
   logic           res_id;
   logic           res_err;
   logic           busy;

   modport master (
      input  req_a, req_b, x_a, d_a, x_b, d_b,
      input  div_in_rd, div_q, div_out_vd, res_rd,
      output gnt_a, gnt_b, div_x, div_d, div_in_vd, div_out_rd,
      output res_vd, res_q, res_id, res_err, busy
   );

   modport slave (
      output req_a, req_b, x_a, d_a, x_b, d_b,
      output div_in_rd, div_q, div_out_vd, res_rd,
      input  gnt_a, gnt_b, div_x, div_d, div_in_vd, div_out_rd,
      input  res_vd, res_q, res_id, res_err, busy
   );
endinterface

// File: rtl/online_div_sequencer.sv
// Two-requester job sequencer for a radix-2 on-line divider: round-robin
// grant, MSD-first operand feed with DELTA zero pads, quotient collection,
// watchdog abort and result hand-off.
module online_div_sequencer #(
   parameter int N       = 8,
   parameter int DELTA   = 3,
   parameter int TIMEOUT = 255
) (
   input logic                    clk,
   input logic                    rst_n,
   online_div_sequencer_if.master bus
);
   localparam int CW = $clog2(N + DELTA + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] IN_LAST = CW'(N + DELTA - 1);
   localparam logic [CW-1:0] Q_LAST  = CW'(N - 1);
   localparam logic [CW-1:0] Q_FULL  = CW'(N);
   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t         state;
   logic [2*N-1:0] x_sr;
   logic [2*N-1:0] d_sr;
   logic [CW-1:0]  in_cnt;
   logic [CW-1:0]  out_cnt;
   logic [TW-1:0]  wd;
   logic           prio_b;

   logic           xfer_in;
   logic           xfer_out;
   logic           in_last;
   logic           out_last;
   logic           q_full;
   logic           wd_hit;
   logic           pick_b;
   logic [2*N-1:0] sel_x;
   logic [2*N-1:0] sel_d;

   // Handshake decode, end-of-phase detection and round-robin selection.
   always_comb begin
      xfer_in  = bus.div_in_vd && bus.div_in_rd;
      xfer_out = bus.div_out_vd && bus.div_out_rd;
      in_last  = xfer_in && (in_cnt == IN_LAST);
      out_last = xfer_out && (out_cnt == Q_LAST);
      q_full   = (out_cnt == Q_FULL) || out_last;
      wd_hit   = !xfer_in && !xfer_out && (wd == WD_LAST);
      pick_b   = bus.req_b && (!bus.req_a || prio_b);
      sel_x    = pick_b ? bus.x_b : bus.x_a;
      sel_d    = pick_b ? bus.d_b : bus.d_a;
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         x_sr           <= '0;
         d_sr           <= '0;
         in_cnt         <= '0;
         out_cnt        <= '0;
         wd             <= '0;
         prio_b         <= 1'b0;
         bus.gnt_a      <= 1'b0;
         bus.gnt_b      <= 1'b0;
         bus.div_x      <= '0;
         bus.div_d      <= '0;
         bus.div_in_vd  <= 1'b0;
         bus.div_out_rd <= 1'b0;
         bus.res_vd     <= 1'b0;
         bus.res_q      <= '0;
         bus.res_id     <= 1'b0;
         bus.res_err    <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         bus.gnt_a <= 1'b0;
         bus.gnt_b <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_a || bus.req_b) begin
                  bus.gnt_a      <= !pick_b;
                  bus.gnt_b      <= pick_b;
                  prio_b         <= !pick_b;
                  bus.res_id     <= pick_b;
                  x_sr           <= sel_x;
                  d_sr           <= sel_d;
                  bus.div_x      <= sel_x[2*N-1 -: 2];
                  bus.div_d      <= sel_d[2*N-1 -: 2];
                  in_cnt         <= '0;
                  out_cnt        <= '0;
                  wd             <= '0;
                  bus.res_q      <= '0;
                  bus.res_err    <= 1'b0;
                  bus.div_in_vd  <= 1'b1;
                  bus.div_out_rd <= 1'b1;
                  bus.busy       <= 1'b1;
                  state          <= FEED;
               end
            end
            FEED, DRAIN: begin
               // Operands shift up with zero fill, so the DELTA pad digits
               // fall out of the shift register after the real digits.
               if (xfer_in) begin
                  in_cnt    <= in_cnt + CW'(1);
                  x_sr      <= {x_sr[2*N-3:0], 2'b00};
                  d_sr      <= {d_sr[2*N-3:0], 2'b00};
                  bus.div_x <= x_sr[2*N-3 -: 2];
                  bus.div_d <= d_sr[2*N-3 -: 2];
                  if (in_last) bus.div_in_vd <= 1'b0;
               end
               if (xfer_out) begin
                  out_cnt <= out_cnt + CW'(1);
                  for (int unsigned i = 0; i < N; i++) begin
                     if (out_cnt == CW'(N - 1 - i)) bus.res_q[2*i +: 2] <= bus.div_q;
                  end
                  if (out_last) bus.div_out_rd <= 1'b0;
               end
               if (xfer_in || xfer_out) wd <= '0;
               else                     wd <= wd + TW'(1);

               if (wd_hit) begin
                  bus.div_in_vd  <= 1'b0;
                  bus.div_out_rd <= 1'b0;
                  bus.res_err    <= 1'b1;
                  bus.res_vd     <= 1'b1;
                  state          <= DONE;
               end else if (state == FEED && in_last) begin
                  if (q_full) begin
                     bus.res_vd <= 1'b1;
                     state      <= DONE;
                  end else begin
                     state <= DRAIN;
                  end
               end else if (state == DRAIN && out_last) begin
                  bus.res_vd <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (bus.res_rd) begin
                  bus.res_vd <= 1'b0;
                  bus.busy   <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_online_div_sequencer.sv
// Directed bench for online_div_sequencer: a scripted divider model returns
// fixed quotient digit tables and logs every digit pair it accepts.
module tb_online_div_sequencer;
   localparam int N = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   online_div_sequencer_if #(.N(N)) bus ();
   online_div_sequencer #(.N(N), .DELTA(3), .TIMEOUT(255)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [15:0] qtab;
   int          q_lat, q_lim, q_idx, in_seen;
   bit          stall;
   logic [21:0] in_xv, in_dv;
   int          last_in_cyc, last_xfer_cyc, res_cyc, stall_seen;
   bit          prev_stall;
   logic [1:0]  prev_x, prev_d;
   int          gnt_log[$];
   logic [15:0] snap;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({bus.gnt_a, bus.gnt_b, bus.div_in_vd, bus.div_out_rd, bus.res_vd,
                  bus.res_err, bus.res_id, bus.busy, bus.div_x, bus.div_d, bus.res_q});
   endfunction

   // One clock: observe at the falling edge, then drive the divider model.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
         $display("FAIL cycle_budget: got %0d expected <= 20000", cyc);
         $fatal(1, "cycle budget exhausted");
      end
      if (bus.gnt_a || bus.gnt_b) check_eq("gnt_overlap", 64'(bus.gnt_a && bus.gnt_b), 64'd0);
      if (bus.gnt_a) gnt_log.push_back(0);
      if (bus.gnt_b) gnt_log.push_back(1);
      if (prev_stall && bus.div_in_vd) begin
         stall_seen++;
         check_eq("stall_stable", 64'({bus.div_x, bus.div_d}), 64'({prev_x, prev_d}));
      end
      bus.div_in_rd  = stall ? (cyc % 3 == 0) : 1'b1;
      bus.div_out_vd = (in_seen >= q_lat) && (q_idx < q_lim);
      bus.div_q      = (q_idx < N) ? qtab[2*(N-1-q_idx) +: 2] : 2'b00;
      if (bus.div_in_vd && bus.div_in_rd) begin
         in_xv = {in_xv[19:0], bus.div_x};
         in_dv = {in_dv[19:0], bus.div_d};
         in_seen++;
         last_in_cyc   = cyc;
         last_xfer_cyc = cyc;
      end
      if (bus.div_out_vd && bus.div_out_rd) begin
         q_idx++;
         last_xfer_cyc = cyc;
      end
      prev_stall = bus.div_in_vd && !bus.div_in_rd;
      prev_x     = bus.div_x;
      prev_d     = bus.div_d;
   endtask

   task automatic start_job(input logic [15:0] qv, input int lat, input int lim, input bit st);
      qtab = qv; q_lat = lat; q_lim = lim; stall = st;
      q_idx = 0; in_seen = 0; in_xv = '0; in_dv = '0;
      stall_seen = 0; prev_stall = 1'b0;
   endtask

   task automatic wait_gnt();
      int n = 0;
      while (!(bus.gnt_a || bus.gnt_b) && n < 40) begin tick(); n++; end
      check_eq("gnt_seen", 64'(bus.gnt_a || bus.gnt_b), 64'd1);
   endtask

   task automatic wait_res(input int limit);
      int n = 0;
      while (!bus.res_vd && n < limit) begin tick(); n++; end
      res_cyc = cyc;
      check_eq("res_vd_seen", 64'(bus.res_vd), 64'd1);
   endtask

   task automatic finish_res();
      bus.res_rd = 1'b1;
      tick();
      bus.res_rd = 1'b0;
      check_eq("res_release", 64'({bus.res_vd, bus.busy}), 64'd0);
   endtask

   task automatic run_a(input logic [15:0] qv, input int lat, input int lim, input bit st);
      start_job(qv, lat, lim, st);
      bus.req_a = 1'b1;
      wait_gnt();
      bus.req_a = 1'b0;
      wait_res(400);
   endtask

   initial begin
      bus.req_a = 0; bus.req_b = 0; bus.x_a = '0; bus.d_a = '0; bus.x_b = '0; bus.d_b = '0;
      bus.div_in_rd = 0; bus.div_q = '0; bus.div_out_vd = 0; bus.res_rd = 0;
      start_job(16'h0000, 4, N, 0);
      tick(); tick();
      check_eq("reset_outs", outs(), 64'd0);
      rst_n = 1'b1;

      // Plain A job; quotient tail digit arrives in DRAIN.
      bus.x_a = 16'h0055; bus.d_a = 16'h0001;
      gnt_log.delete();
      start_job(16'h9A61, 4, N, 0);
      bus.req_a = 1'b1;
      wait_gnt();
      bus.req_a = 1'b0;
      check_eq("j1_gnt_a", 64'(bus.gnt_a), 64'd1);
      check_eq("j1_busy", 64'(bus.busy), 64'd1);
      tick();
      check_eq("j1_gnt_pulse", 64'(bus.gnt_a), 64'd0);
      wait_res(100);
      check_eq("j1_in_count", 64'(in_seen), 64'd11);
      check_eq("j1_x_digits", 64'(in_xv), 64'({16'h0055, 6'b0}));
      check_eq("j1_d_digits", 64'(in_dv), 64'({16'h0001, 6'b0}));
      check_eq("j1_out_count", 64'(q_idx), 64'd8);
      check_eq("j1_res_q", 64'(bus.res_q), 64'h9A61);
      check_eq("j1_id_err", 64'({bus.res_id, bus.res_err}), 64'd0);
      check_eq("j1_drain_lat", 64'(res_cyc - last_in_cyc), 64'd2);
      check_eq("j1_grants", 64'(gnt_log.size()), 64'd1);
      finish_res();

      // Both requesting from reset: A, B, then A again.
      rst_n = 1'b0; bus.req_a = 1'b1; bus.req_b = 1'b1;
      tick();
      check_eq("rr_reset_outs", outs(), 64'd0);
      rst_n = 1'b1;
      bus.x_b = 16'h2400; bus.d_b = 16'h0104;
      bus.res_rd = 1'b1;
      gnt_log.delete();
      for (int j = 0; j < 3; j++) begin
         start_job(16'h1000 + 16'(j), 4, N, 0);
         wait_gnt();
         if (j == 2) begin bus.req_a = 1'b0; bus.req_b = 1'b0; end
         wait_res(100);
         check_eq("rr_res_id", 64'(bus.res_id), 64'(j == 1));
         check_eq("rr_res_q", 64'(bus.res_q), 64'(16'h1000 + 16'(j)));
         check_eq("rr_x_digits", 64'(in_xv), 64'({(j == 1) ? 16'h2400 : 16'h0055, 6'b0}));
      end
      tick();
      bus.res_rd = 1'b0;
      check_eq("rr_count", 64'(gnt_log.size()), 64'd3);
      check_eq("rr_order", 64'(gnt_log[0] * 4 + gnt_log[1] * 2 + gnt_log[2]), 64'd2);

      // Divider input ready only one cycle in three.
      bus.x_a = 16'h1A49; bus.d_a = 16'h6295;
      run_a(16'h4629, 4, N, 1);
      check_eq("st_in_count", 64'(in_seen), 64'd11);
      check_eq("st_x_digits", 64'(in_xv), 64'({16'h1A49, 6'b0}));
      check_eq("st_d_digits", 64'(in_dv), 64'({16'h6295, 6'b0}));
      check_eq("st_stalls_seen", 64'(stall_seen > 0), 64'd1);
      check_eq("st_res_q", 64'(bus.res_q), 64'h4629);
      finish_res();

      // All quotient digits captured before the feed ends; extras refused.
      bus.x_a = 16'h8001; bus.d_a = 16'h4000;
      run_a(16'h5A5A, 1, N + 2, 0);
      check_eq("dd_out_count", 64'(q_idx), 64'd8);
      check_eq("dd_res_q", 64'(bus.res_q), 64'h5A5A);
      check_eq("dd_err", 64'(bus.res_err), 64'd0);
      check_eq("dd_direct_done", 64'(res_cyc - last_in_cyc), 64'd1);
      check_eq("dd_x_digits", 64'(in_xv), 64'({16'h8001, 6'b0}));
      finish_res();

      // Quotient stops after 4 digits: last transfer, 255 idle edges, result
      // visible on the following cycle.
      run_a(16'h9999, 4, 4, 0);
      check_eq("to_err", 64'(bus.res_err), 64'd1);
      check_eq("to_res_q", 64'(bus.res_q), 64'h9900);
      check_eq("to_out_count", 64'(q_idx), 64'd4);
      check_eq("to_delay", 64'(res_cyc - last_xfer_cyc), 64'd256);
      finish_res();

      // Result held 20 cycles with B waiting.
      run_a(16'h6A15, 4, N, 0);
      snap = bus.res_q;
      bus.req_b = 1'b1; bus.x_b = 16'h0421;
      gnt_log.delete();
      repeat (20) begin
         tick();
         check_eq("hold_res", 64'({bus.res_vd, bus.res_id, bus.res_err, bus.res_q}), 64'({3'b100, 16'h6A15}));
      end
      check_eq("hold_snap", 64'(snap), 64'h6A15);
      check_eq("hold_no_gnt", 64'(gnt_log.size()), 64'd0);
      start_job(16'h2104, 4, N, 0);
      bus.res_rd = 1'b1;
      tick();
      bus.res_rd = 1'b0;
      check_eq("hold_release", 64'({bus.res_vd, bus.gnt_b}), 64'd0);
      tick();
      check_eq("hold_gnt_b", 64'(bus.gnt_b), 64'd1);
      bus.req_b = 1'b0;
      wait_res(100);
      check_eq("hold_b_id", 64'(bus.res_id), 64'd1);
      check_eq("hold_b_res_q", 64'(bus.res_q), 64'h2104);
      check_eq("hold_b_x", 64'(in_xv), 64'({16'h0421, 6'b0}));
      finish_res();

      // Reset pulse in the middle of FEED, then a clean job.
      start_job(16'h1111, 4, N, 0);
      bus.req_a = 1'b1;
      wait_gnt();
      bus.req_a = 1'b0;
      tick(); tick();
      check_eq("mid_in_feed", 64'(bus.div_in_vd), 64'd1);
      rst_n = 1'b0;
      tick();
      check_eq("mid_reset_outs", outs(), 64'd0);
      rst_n = 1'b1;
      tick();
      check_eq("mid_idle", outs(), 64'd0);
      bus.x_a = 16'h0055;
      run_a(16'h8421, 4, N, 0);
      check_eq("mid_in_count", 64'(in_seen), 64'd11);
      check_eq("mid_res_q", 64'(bus.res_q), 64'h8421);
      check_eq("mid_id_err", 64'({bus.res_id, bus.res_err}), 64'd0);
      finish_res();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
